// File: rtl/mic_pkg.sv
// Shared types and constants for the microphone sample FIFO / byte serializer.
package mic_pkg;
    localparam int SAMPLE_W         = 32;
    localparam int BYTES_PER_SAMPLE = 4;
    localparam int BYTE_IDX_W       = 2;
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BYTES_PER_SAMPLE - 1);

    typedef enum logic {IN_IDLE, IN_WAIT} in_state_e;
    typedef enum logic {OUT_IDLE, OUT_SEND} out_state_e;
endpackage

// File: rtl/mic_sample_fifo_if.sv
// Sample-in (valid/retrieved) and byte-out (valid/ready) signals of the sample FIFO.
// Handshakes: a sample is taken on a one-cycle mic_data_retrieved pulse while
// mic_data_valid is held; a byte transfers on any edge with out_valid && out_ready,
// and out_byte/out_valid never change while out_valid && !out_ready.
interface mic_sample_fifo_if;
    logic [mic_pkg::SAMPLE_W-1:0] mic_data;
    logic                         mic_data_valid;
    logic                         mic_data_retrieved;
    logic [7:0]                   out_byte;
    logic                         out_valid;
    logic                         out_ready;

    modport slave (
        input  mic_data, mic_data_valid, out_ready,
        output mic_data_retrieved, out_byte, out_valid
    );
    modport master (
        output mic_data, mic_data_valid, out_ready,
        input  mic_data_retrieved, out_byte, out_valid
    );
endinterface

// File: rtl/mic_fifo_mem.sv
// DEPTH x SAMPLE_W register FIFO: synchronous write, combinational read at the read pointer.
module mic_fifo_mem
    import mic_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [SAMPLE_W-1:0] wr_data_i,
    output logic [SAMPLE_W-1:0] rd_data_o,
    output logic [ADDR_W:0]     count_o,
    output logic                full_o,
    output logic                empty_o
);
    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                do_push, do_pop;

    assign full_o    = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o && !flush_i;
    assign do_pop    = pop_i && !empty_o && !flush_i;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointers wrap naturally at DEPTH; count alone tells full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + (ADDR_W+1)'(1);
            else if (!do_push && do_pop) count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/mic_sample_fifo.sv
// Buffers stereo mic samples and serializes them MSB-first as bytes.
// Optional MIC_DROP_COUNT_EN: acknowledge-and-drop when full, with a saturating drop_count.
module mic_sample_fifo
    import mic_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  mon_clk,
    input  logic                  reset,
    input  logic                  flush,
    mic_sample_fifo_if.slave      bus,
    output logic [ADDR_W:0]       fifo_count,
`ifdef MIC_DROP_COUNT_EN
    output logic [15:0]           drop_count,
`endif
    output in_state_e             dbg_in_state,
    output out_state_e            dbg_out_state
);
    in_state_e             in_state_q, in_state_d;
    out_state_e            out_state_q, out_state_d;
    logic                  retrieved_q, retrieved_d;
    logic [SAMPLE_W-1:0]   shreg_q, shreg_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic                  push, pop, fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0]   rd_data;
`ifdef MIC_DROP_COUNT_EN
    logic                  drop;
    logic [15:0]           drop_count_q;
`endif

    mic_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk_i     (mon_clk),
        .reset_i   (reset),
        .flush_i   (flush),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (bus.mic_data),
        .rd_data_o (rd_data),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // IN_WAIT holds until valid drops so a held sample is captured only once.
    always_comb begin
        in_state_d  = in_state_q;
        push        = 1'b0;
        retrieved_d = 1'b0;
`ifdef MIC_DROP_COUNT_EN
        drop        = 1'b0;
`endif
        if (!flush) begin
            case (in_state_q)
                IN_IDLE: begin
                    if (bus.mic_data_valid) begin
                        if (!fifo_full) begin
                            push        = 1'b1;
                            retrieved_d = 1'b1;
                            in_state_d  = IN_WAIT;
                        end
`ifdef MIC_DROP_COUNT_EN
                        else begin
                            drop        = 1'b1;
                            retrieved_d = 1'b1;
                            in_state_d  = IN_WAIT;
                        end
`endif
                    end
                end
                IN_WAIT: if (!bus.mic_data_valid) in_state_d = IN_IDLE;
                default: in_state_d = IN_IDLE;
            endcase
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        pop         = 1'b0;
        if (flush) begin
            out_state_d = OUT_IDLE;
            shreg_d     = '0;
            idx_d       = '0;
        end else begin
            case (out_state_q)
                OUT_IDLE: begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        shreg_d     = rd_data;
                        idx_d       = LAST_BYTE_IDX;
                        out_state_d = OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    if (bus.out_ready) begin
                        if (idx_q != '0) begin
                            shreg_d = {shreg_q[SAMPLE_W-9:0], 8'h00};
                            idx_d   = idx_q - BYTE_IDX_W'(1);
                        end else if (!fifo_empty) begin
                            // Reload on the last byte so words stream without a bubble.
                            pop     = 1'b1;
                            shreg_d = rd_data;
                            idx_d   = LAST_BYTE_IDX;
                        end else begin
                            shreg_d     = '0;
                            out_state_d = OUT_IDLE;
                        end
                    end
                end
                default: out_state_d = OUT_IDLE;
            endcase
        end
    end

    always_ff @(posedge mon_clk) begin
        if (reset) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            retrieved_q <= 1'b0;
            shreg_q     <= '0;
            idx_q       <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            retrieved_q <= retrieved_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
        end
    end

`ifdef MIC_DROP_COUNT_EN
    always_ff @(posedge mon_clk) begin
        if (reset || flush) drop_count_q <= '0;
        else if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
    assign drop_count = drop_count_q;
`endif

    assign bus.mic_data_retrieved = retrieved_q;
    assign bus.out_valid          = (out_state_q == OUT_SEND);
    assign bus.out_byte           = shreg_q[SAMPLE_W-1 -: 8];
    assign dbg_in_state           = in_state_q;
    assign dbg_out_state          = out_state_q;
endmodule

// File: tb/tb_mic_sample_fifo.sv
// Directed bench for mic_sample_fifo: byte-queue model checked every cycle plus literal pins.
module tb_mic_sample_fifo;
    import mic_pkg::*;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [ADDR_W:0]   fifo_count;
    in_state_e         dbg_in_state;
    out_state_e        dbg_out_state;
`ifdef MIC_DROP_COUNT_EN
    logic [15:0]       drop_count;
`endif

    mic_sample_fifo_if bus ();

    mic_sample_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .mon_clk       (clk),
        .reset         (reset),
        .flush         (flush),
        .bus           (bus),
        .fifo_count    (fifo_count),
`ifdef MIC_DROP_COUNT_EN
        .drop_count    (drop_count),
`endif
        .dbg_in_state  (dbg_in_state),
        .dbg_out_state (dbg_out_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int ack_cnt      = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         got_cyc [$];
    logic       stall_q = 1'b0;
    logic [7:0] stall_byte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.mic_data_retrieved === 1'b1) ack_cnt++;
    end

    // scoreboard: every accepted byte must be the next byte the model expects
    always @(negedge clk) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stall_byte", {24'd0, bus.out_byte}, {24'd0, stall_byte});
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_byte", {31'd0, bus.out_valid}, 32'd0);
                end else if (bus.out_ready) begin
                    check("byte", {24'd0, bus.out_byte}, {24'd0, exp_q.pop_front()});
                    got_q.push_back(bus.out_byte);
                    got_cyc.push_back(cyc);
                end
            end
            stall_q    = bus.out_valid && !bus.out_ready && !flush;
            stall_byte = bus.out_byte;
            if (flush) exp_q.delete();
        end
    end

    // driver tasks
    task automatic expect_word(input logic [31:0] d);
        for (int b = 3; b >= 0; b--) exp_q.push_back(d[8*b +: 8]);
    endtask

    task automatic send_sample(input logic [31:0] d, input bit kept);
        int start = ack_cnt;
        int t = 0;
        if (kept) expect_word(d);
        bus.mic_data       = d;
        bus.mic_data_valid = 1'b1;
        while (ack_cnt == start && t < 200) begin
            tick();
            t++;
        end
        check("ack_one", ack_cnt - start, 1);
        bus.mic_data_valid = 1'b0;
        tick();
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        check("drain_left", exp_q.size(), 0);
        tick(3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int a0;
        int t;
        reset              = 1'b1;
        flush              = 1'b0;
        bus.mic_data       = '0;
        bus.mic_data_valid = 1'b0;
        bus.out_ready      = 1'b0;
        do_reset();

        // reset state
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_byte", {24'd0, bus.out_byte}, 32'd0);
        check("rst_count", {28'd0, fifo_count}, 32'd0);
        check("rst_retrieved", {31'd0, bus.mic_data_retrieved}, 32'd0);
        check("rst_in_state", {31'd0, dbg_in_state}, {31'd0, IN_IDLE});
        check("rst_out_state", {31'd0, dbg_out_state}, {31'd0, OUT_IDLE});

        // single sample streams out as 4 back-to-back bytes
        base = got_q.size();
        a0 = ack_cnt;
        bus.out_ready = 1'b1;
        send_sample(32'h5a5aa5a5, 1'b1);
        wait_drain();
        check("t1_b0", {24'd0, got_q[base]}, 32'h5a);
        check("t1_b1", {24'd0, got_q[base+1]}, 32'h5a);
        check("t1_b2", {24'd0, got_q[base+2]}, 32'ha5);
        check("t1_b3", {24'd0, got_q[base+3]}, 32'ha5);
        check("t1_span", got_cyc[base+3] - got_cyc[base], 3);
        check("t1_acks", ack_cnt - a0, 1);
        check("t1_count", {28'd0, fifo_count}, 32'd0);

        // fill with downstream stalled: serializer holds word 1, FIFO holds 2..9
        bus.out_ready = 1'b0;
        base = got_q.size();
        a0 = ack_cnt;
        for (int i = 1; i <= 9; i++) send_sample(32'(i), 1'b1);
        check("t2_count_full", {28'd0, fifo_count}, 32'd8);
`ifdef MIC_DROP_COUNT_EN
        send_sample(32'd10, 1'b0);
        check("t3_drop_count", {16'd0, drop_count}, 32'd1);
        check("t3_count", {28'd0, fifo_count}, 32'd8);
        check("t3_acks", ack_cnt - a0, 10);
        bus.out_ready = 1'b1;
        wait_drain();
        check("t3_span", got_cyc[base+35] - got_cyc[base], 35);
        check("t3_first", {24'd0, got_q[base+3]}, 32'h01);
        check("t3_last", {24'd0, got_q[base+35]}, 32'h09);
        check("t3_total", got_q.size() - base, 36);
`else
        expect_word(32'd10);
        bus.mic_data       = 32'd10;
        bus.mic_data_valid = 1'b1;
        tick(10);
        check("t2_stall_acks", ack_cnt - a0, 9);
        check("t2_stall_count", {28'd0, fifo_count}, 32'd8);
        check("t2_no_retrieved", {31'd0, bus.mic_data_retrieved}, 32'd0);
        bus.out_ready = 1'b1;
        t = 0;
        while (ack_cnt - a0 == 9 && t < 200) begin
            tick();
            t++;
        end
        check("t2_tenth_ack", ack_cnt - a0, 10);
        bus.mic_data_valid = 1'b0;
        wait_drain();
        check("t2_span", got_cyc[base+39] - got_cyc[base], 39);
        check("t2_first", {24'd0, got_q[base+3]}, 32'h01);
        check("t2_tenth_hi", {24'd0, got_q[base+36]}, 32'h00);
        check("t2_last", {24'd0, got_q[base+39]}, 32'h0a);
`endif

        // out_ready toggling: bytes must hold while stalled
        bus.out_ready = 1'b0;
        base = got_q.size();
        send_sample(32'hffff0001, 1'b1);
        for (int i = 0; i < 16; i++) begin
            bus.out_ready = i[0];
            tick();
        end
        bus.out_ready = 1'b1;
        wait_drain();
        check("t4_b0", {24'd0, got_q[base]}, 32'hff);
        check("t4_b1", {24'd0, got_q[base+1]}, 32'hff);
        check("t4_b2", {24'd0, got_q[base+2]}, 32'h00);
        check("t4_b3", {24'd0, got_q[base+3]}, 32'h01);

        // flush after two bytes of a word with three more queued
        bus.out_ready = 1'b0;
        send_sample(32'h96969696, 1'b1);
        send_sample(32'h11111111, 1'b1);
        send_sample(32'h22222222, 1'b1);
        send_sample(32'h33333333, 1'b1);
        check("t5_queued", {28'd0, fifo_count}, 32'd3);
        base = got_q.size();
        bus.out_ready = 1'b1;
        t = 0;
        while (got_q.size() - base < 2 && t < 100) begin
            tick();
            t++;
        end
        bus.out_ready = 1'b0;
        check("t5_two_bytes", got_q.size() - base, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_valid_low", {31'd0, bus.out_valid}, 32'd0);
        check("t5_count", {28'd0, fifo_count}, 32'd0);
`ifdef MIC_DROP_COUNT_EN
        check("t5_drop_clr", {16'd0, drop_count}, 32'd0);
`endif
        bus.out_ready = 1'b1;
        tick(8);
        check("t5_nothing_more", got_q.size() - base, 2);
        base = got_q.size();
        send_sample(32'haaaaaaaa, 1'b1);
        wait_drain();
        check("t5_after_b0", {24'd0, got_q[base]}, 32'haa);
        check("t5_after_b3", {24'd0, got_q[base+3]}, 32'haa);
        check("t5_after_span", got_cyc[base+3] - got_cyc[base], 3);

        // valid held long after retrieved: captured once
        bus.out_ready = 1'b0;
        send_sample(32'h01020304, 1'b1);
        a0 = ack_cnt;
        expect_word(32'h0badcafe);
        bus.mic_data       = 32'h0badcafe;
        bus.mic_data_valid = 1'b1;
        t = 0;
        while (ack_cnt == a0 && t < 100) begin
            tick();
            t++;
        end
        tick(10);
        check("t6_acks", ack_cnt - a0, 1);
        check("t6_count", {28'd0, fifo_count}, 32'd1);
        bus.mic_data_valid = 1'b0;
        tick(2);
        check("t6_count_after", {28'd0, fifo_count}, 32'd1);
        base = got_q.size();
        bus.out_ready = 1'b1;
        wait_drain();
        check("t6_last", {24'd0, got_q[base+7]}, 32'hfe);

        // reset mid-word: nothing further emitted
        bus.out_ready = 1'b0;
        send_sample(32'hdeadbeef, 1'b1);
        base = got_q.size();
        bus.out_ready = 1'b1;
        t = 0;
        while (got_q.size() == base && t < 100) begin
            tick();
            t++;
        end
        do_reset();
        check("t7_valid_low", {31'd0, bus.out_valid}, 32'd0);
        check("t7_count", {28'd0, fifo_count}, 32'd0);
        tick(8);
        check("t7_one_byte", got_q.size() - base, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
